csa_accumulator: RTL and testbench

Streaming multi-operand adder built on a 3:2 carry-save stage. Operands arrive one per cycle and are summed in redundant sum/carry form, so there is no carry propagation in the accumulate loop. On the last operand, one carry-propagate add resolves the total, which is held on a valid/ready output. This is the parametrised, sequential successor of the fixed 16-bit three-operand carry-save adder. It feeds dot-product and checksum datapaths.

---
 rtl/csa_accumulator.sv | 95 +++++++++
 tb/tb_csa_accumulator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// Streaming multi-operand adder: operands are folded into redundant sum/carry
// registers through a 3:2 carry-save stage, then resolved by one carry-propagate add.
module csa_accumulator #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int SIGNED    = 0,
  parameter int CNT_W     = ACC_WIDTH - WIDTH + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds data stable while valid && !ready, and ready never depends on valid.

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  localparam logic [CNT_W-1:0] OVF_LIM = CNT_W'(1) << (ACC_WIDTH - WIDTH);

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] s_reg, c_reg;
  logic [ACC_WIDTH-1:0] ext, cs;
  logic [CNT_W-1:0]     count;
  logic                 accept;

  always_comb begin
    ext = {{(ACC_WIDTH-WIDTH){1'b0}}, in_data};
    if (SIGNED != 0)
      ext = {{(ACC_WIDTH-WIDTH){in_data[WIDTH-1]}}, in_data};
  end

  // Carry vector is weighted one bit higher; its MSB falls off (mod 2^ACC_WIDTH).
  assign cs       = {c_reg[ACC_WIDTH-2:0], 1'b0};
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nxt = RESOLVE;
      RESOLVE: state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      s_reg     <= '0;
      c_reg     <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ACCUM: begin
          if (accept) begin
            s_reg <= ext ^ s_reg ^ cs;
            c_reg <= (ext & s_reg) | (ext & cs) | (s_reg & cs);
            if (count != '1) count <= count + CNT_W'(1);
          end
        end
        RESOLVE: begin
          out_sum   <= s_reg + cs;
          out_count <= count;
          out_ovf   <= (count > OVF_LIM);
          out_valid <= 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            s_reg     <= '0;
            c_reg     <= '0;
            count     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: an unsigned and a signed instance share
// one stimulus stream; expected sums are hand-computed constants.
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_u, out_valid_u, out_ovf_u;
  logic [23:0] out_sum_u;
  logic [9:0]  out_count_u;
  logic        in_ready_s, out_valid_s, out_ovf_s;
  logic [23:0] out_sum_s;
  logic [9:0]  out_count_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.WIDTH(16), .ACC_WIDTH(24), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_sum(out_sum_u), .out_count(out_count_u),
    .out_ovf(out_ovf_u)
  );

  csa_accumulator #(.WIDTH(16), .ACC_WIDTH(24), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_sum(out_sum_s), .out_count(out_count_s),
    .out_ovf(out_ovf_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input logic [15:0] d, input logic last);
    int n = 0;
    while (!in_ready_u && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_ready_timeout", {31'b0, in_ready_u}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid_u && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", {31'b0, out_valid_u}, 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("take_valid_low", {31'b0, out_valid_u}, 32'd0);
    check("take_ready_high", {31'b0, in_ready_u}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, out_valid_u}, 32'd0);
    check("rst_sum", {8'b0, out_sum_u}, 32'd0);
    check("rst_count", {22'b0, out_count_u}, 32'd0);
    check("rst_ovf", {31'b0, out_ovf_u}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready_u}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Three 0xFFFF operands; also checks the output latency
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b1);
    check("lat_resolve_valid", {31'b0, out_valid_u}, 32'd0);
    check("lat_resolve_ready", {31'b0, in_ready_u}, 32'd0);
    @(negedge clk);
    check("lat_out_valid", {31'b0, out_valid_u}, 32'd1);
    check("u3_sum", {8'b0, out_sum_u}, 32'h02FFFD);
    check("u3_count", {22'b0, out_count_u}, 32'd3);
    check("u3_ovf", {31'b0, out_ovf_u}, 32'd0);
    check("s3_sum", {8'b0, out_sum_s}, 32'hFFFFFD);
    take();

    // Signed: -1 + -1 + 5
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'h0005, 1'b1);
    wait_valid();
    check("s_sum", {8'b0, out_sum_s}, 32'h000003);
    check("s_count", {22'b0, out_count_s}, 32'd3);
    check("s_ovf", {31'b0, out_ovf_s}, 32'd0);
    check("u_mix_sum", {8'b0, out_sum_u}, 32'h020003);
    take();

    // Single-beat burst
    send(16'h8000, 1'b1);
    wait_valid();
    check("s_single_sum", {8'b0, out_sum_s}, 32'hFF8000);
    check("s_single_count", {22'b0, out_count_s}, 32'd1);
    check("u_single_sum", {8'b0, out_sum_u}, 32'h008000);
    take();

    // 257 beats exceeds the safe bound
    for (int i = 0; i < 257; i++) send(16'hFFFF, (i == 256));
    wait_valid();
    check("ovf257_sum", {8'b0, out_sum_u}, 32'h00FEFF);
    check("ovf257_count", {22'b0, out_count_u}, 32'd257);
    check("ovf257_ovf", {31'b0, out_ovf_u}, 32'd1);
    check("s_ovf257_sum", {8'b0, out_sum_s}, 32'hFFFEFF);
    check("s_ovf257_ovf", {31'b0, out_ovf_s}, 32'd1);
    take();

    // 256 beats sits exactly on the bound: 256 * 0xFFFF = 0xFFFF00
    for (int i = 0; i < 256; i++) send(16'hFFFF, (i == 255));
    wait_valid();
    check("b256_sum", {8'b0, out_sum_u}, 32'hFFFF00);
    check("b256_count", {22'b0, out_count_u}, 32'd256);
    check("b256_ovf", {31'b0, out_ovf_u}, 32'd0);
    take();

    // Backpressure, then a second burst with no residue
    send(16'd5, 1'b0);
    send(16'd6, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, out_valid_u}, 32'd1);
      check("bp_sum", {8'b0, out_sum_u}, 32'd11);
      check("bp_in_ready", {31'b0, in_ready_u}, 32'd0);
    end
    take();
    send(16'd1, 1'b0);
    send(16'd2, 1'b1);
    wait_valid();
    check("b2_sum", {8'b0, out_sum_u}, 32'd3);
    check("b2_count", {22'b0, out_count_u}, 32'd2);
    take();

    // Gapped input; in_last without in_valid must be ignored
    send(16'd10, 1'b0);
    in_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_last = 1'b0;
    check("gap_ready", {31'b0, in_ready_u}, 32'd1);
    send(16'd20, 1'b0);
    send(16'd30, 1'b1);
    wait_valid();
    check("gap_sum", {8'b0, out_sum_u}, 32'd60);
    check("gap_count", {22'b0, out_count_u}, 32'd3);
    take();

    // Reset mid-burst discards partial state
    send(16'd100, 1'b0);
    send(16'd100, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_valid", {31'b0, out_valid_u}, 32'd0);
    send(16'd7, 1'b1);
    wait_valid();
    check("rst_mid_sum", {8'b0, out_sum_u}, 32'd7);
    check("rst_mid_count", {22'b0, out_count_u}, 32'd1);

    // Reset while holding a result
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_valid", {31'b0, out_valid_u}, 32'd0);
    check("rst_out_ready", {31'b0, in_ready_u}, 32'd1);
    check("rst_out_sum", {8'b0, out_sum_u}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
